// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, reads program memory combinationally and registers the instruction into IF/ID one edge later.
// A decode stall holds PC, IF/ID and the count; a jump or branch redirect flushes IF/ID; the halt opcode freezes fetch until reset.
module instruction_fetch #(
  parameter int          PC_WIDTH   = 11,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  output logic [31:0]          mem_dir,
  input  logic [31:0]          mem_instr,
  output logic [31:0]          ifid_instr,
  output logic [PC_WIDTH-1:0]  ifid_pc_plus1,
  output logic                 ifid_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [31:0]          r_ifid_instr;
  logic [PC_WIDTH-1:0]  r_ifid_pc_plus1;
  logic                 r_ifid_valid;
  logic [CNT_WIDTH-1:0] r_fetch_count;

  state_t               w_state_nxt;
  logic [PC_WIDTH-1:0]  w_pc_nxt;
  logic [31:0]          w_ifid_instr_nxt;
  logic [PC_WIDTH-1:0]  w_ifid_pc_plus1_nxt;
  logic                 w_ifid_valid_nxt;
  logic [CNT_WIDTH-1:0] w_fetch_count_nxt;
  logic [PC_WIDTH-1:0]  w_pc_plus1;

  assign w_pc_plus1 = r_pc + PC_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_pc            <= '0;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus1 <= '0;
      r_ifid_valid    <= 1'b0;
      r_fetch_count   <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_ifid_instr    <= w_ifid_instr_nxt;
      r_ifid_pc_plus1 <= w_ifid_pc_plus1_nxt;
      r_ifid_valid    <= w_ifid_valid_nxt;
      r_fetch_count   <= w_fetch_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_ifid_instr_nxt    = r_ifid_instr;
    w_ifid_pc_plus1_nxt = r_ifid_pc_plus1;
    w_ifid_valid_nxt    = r_ifid_valid;
    w_fetch_count_nxt   = r_fetch_count;

    unique case (r_state)
      S_IDLE: begin
        // The edge that leaves IDLE does not fetch; address 0 is captured one edge later.
        w_pc_nxt         = '0;
        w_ifid_instr_nxt = NOP_INSTR;
        w_ifid_valid_nxt = 1'b0;
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (jump || branch_taken) begin
          w_pc_nxt         = jump ? jump_target : branch_target;
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (mem_instr == HALT_INSTR) begin
          w_state_nxt      = S_HALTED;
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
        end else begin
          w_pc_nxt            = w_pc_plus1;
          w_ifid_instr_nxt    = mem_instr;
          w_ifid_pc_plus1_nxt = w_pc_plus1;
          w_ifid_valid_nxt    = 1'b1;
          if (r_fetch_count != CNT_MAX) w_fetch_count_nxt = r_fetch_count + CNT_ONE;
        end
      end
      S_HALTED: begin
        w_ifid_instr_nxt = NOP_INSTR;
        w_ifid_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_dir       = {{(32-PC_WIDTH){1'b0}}, r_pc};
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus1 = r_ifid_pc_plus1;
  assign ifid_valid    = r_ifid_valid;
  assign halted        = (r_state == S_HALTED);
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational program memory holding mem[k] = k + 100.
module tb_instruction_fetch;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [10:0] branch_target;
  logic        jump;
  logic [10:0] jump_target;
  logic [31:0] mem_dir;
  logic [31:0] mem_instr;
  logic [31:0] ifid_instr;
  logic [10:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:2047];
  int errors = 0;
  int checks = 0;

  instruction_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .mem_dir      (mem_dir),
    .mem_instr    (mem_instr),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid   (ifid_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  assign mem_instr = mem[mem_dir[10:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_dir, input logic [31:0] e_instr,
                         input logic [31:0] e_pp1, input logic e_vld, input logic e_halt,
                         input logic [31:0] e_cnt);
    chk({tag, ".mem_dir"}, mem_dir, e_dir);
    chk({tag, ".ifid_instr"}, ifid_instr, e_instr);
    chk({tag, ".ifid_pc_plus1"}, {21'd0, ifid_pc_plus1}, e_pp1);
    chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_vld});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
    chk({tag, ".fetch_count"}, {16'd0, fetch_count}, e_cnt);
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = k + 100;
    reset_n = 1'b0; start = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;

    // IDLE ignores redirects and stalls
    branch_taken = 1'b1; branch_target = 11'd40; jump = 1'b1; jump_target = 11'd7; stall = 1'b1;
    step();
    chk_all("idle_ignore", 0, 0, 0, 0, 0, 0);
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;

    start = 1'b1;
    step();
    chk_all("start_edge", 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    step();
    chk_all("fetch0", 1, 100, 1, 1, 0, 1);
    step();
    chk_all("fetch1", 2, 101, 2, 1, 0, 2);

    stall = 1'b1;
    step();
    chk_all("stall1", 2, 101, 2, 1, 0, 2);
    step();
    chk_all("stall2", 2, 101, 2, 1, 0, 2);
    stall = 1'b0;
    step();
    chk_all("resume2", 3, 102, 3, 1, 0, 3);
    step();
    chk_all("fetch3", 4, 103, 4, 1, 0, 4);
    step();
    chk_all("fetch4", 5, 104, 5, 1, 0, 5);

    branch_taken = 1'b1; branch_target = 11'd40; stall = 1'b1;
    step();
    chk_all("branch_flush", 40, 0, 5, 0, 0, 5);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    chk_all("branch_fetch", 41, 140, 41, 1, 0, 6);

    jump = 1'b1; jump_target = 11'd7; branch_taken = 1'b1; branch_target = 11'd40;
    step();
    chk_all("jump_prio", 7, 0, 41, 0, 0, 6);
    jump = 1'b0; branch_taken = 1'b0;
    step();
    chk_all("jump_fetch", 8, 107, 8, 1, 0, 7);

    jump = 1'b1; jump_target = 11'd2047;
    step();
    chk_all("jump_top", 2047, 0, 8, 0, 0, 7);
    jump = 1'b0;
    step();
    chk_all("pc_wrap", 0, 2147, 0, 1, 0, 8);

    // asynchronous reset mid-run, observed before the next edge
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;

    mem[3] = 32'hFFFF_FFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("h_start", 0, 0, 0, 0, 0, 0);
    step();
    chk_all("h_fetch0", 1, 100, 1, 1, 0, 1);
    step();
    chk_all("h_fetch1", 2, 101, 2, 1, 0, 2);
    step();
    chk_all("h_fetch2", 3, 102, 3, 1, 0, 3);
    step();
    chk_all("halt", 3, 0, 3, 0, 1, 3);
    branch_taken = 1'b1; branch_target = 11'd40; jump = 1'b1; jump_target = 11'd7; start = 1'b1;
    step();
    chk_all("halt_ign1", 3, 0, 3, 0, 1, 3);
    jump = 1'b0;
    step();
    chk_all("halt_ign2", 3, 0, 3, 0, 1, 3);
    branch_taken = 1'b0; start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
